// File: rtl/aes_pkg.sv
// aes_pkg: widths and controller state encoding shared by the AES output path.
package aes_pkg;
   localparam int AES_BLOCK_W = 128;
   localparam int BYTE_W      = 8;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } state_t;
endpackage

// File: rtl/aes_byte_tx_ctrl.sv
// aes_byte_tx_ctrl: accepts a 128-bit AES block and feeds it byte by byte to the serializer,
// advancing on ser_done, aborting a stalled byte after TIMEOUT cycles.
module aes_byte_tx_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_BYTES = 16,
   parameter int MSB_FIRST = 1,
   parameter int GAP_CYC   = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic                   blk_valid,
   input  logic [AES_BLOCK_W-1:0] blk_data,
   output logic                   blk_ready,
   output logic [BYTE_W-1:0]      ser_data,
   output logic                   ser_en,
   input  logic                   ser_done,
   output logic                   busy,
   output logic [3:0]             byte_idx,
   output logic                   blk_done,
   output logic                   err_timeout
);
   localparam int TW = $clog2(TIMEOUT + 2);
   localparam int GW = $clog2(GAP_CYC + 2);
   localparam logic [3:0]    LAST_IDX = 4'(NUM_BYTES - 1);
   localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);
   localparam logic [GW-1:0] G_LAST   = GW'(GAP_CYC - 1);

   state_t                 state_q, state_d;
   logic [AES_BLOCK_W-1:0] shreg_q, shreg_d, shreg_nx;
   logic [3:0]             byte_idx_q, byte_idx_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [GW-1:0]          gap_q, gap_d;
   logic [BYTE_W-1:0]      ser_data_q, ser_data_d;
   logic                   blk_ready_q, blk_ready_d;
   logic                   ser_en_q, ser_en_d;
   logic                   busy_q, busy_d;
   logic                   blk_done_q, blk_done_d;
   logic                   err_timeout_q, err_timeout_d;

   function automatic logic [BYTE_W-1:0] head(input logic [AES_BLOCK_W-1:0] s);
      return (MSB_FIRST != 0) ? s[AES_BLOCK_W-1 -: BYTE_W] : s[BYTE_W-1:0];
   endfunction

   always_comb begin
      shreg_nx      = (MSB_FIRST != 0) ? shreg_q << BYTE_W : shreg_q >> BYTE_W;
      state_d       = state_q;
      shreg_d       = shreg_q;
      byte_idx_d    = byte_idx_q;
      timer_d       = timer_q;
      gap_d         = gap_q;
      ser_data_d    = ser_data_q;
      ser_en_d      = ser_en_q;
      busy_d        = busy_q;
      blk_done_d    = 1'b0;
      err_timeout_d = 1'b0;
      case (state_q)
         IDLE: if (blk_valid && blk_ready_q) begin
            state_d    = LOAD;
            shreg_d    = blk_data;
            byte_idx_d = '0;
            timer_d    = '0;
            gap_d      = '0;
            busy_d     = 1'b1;
         end
         LOAD: begin
            ser_data_d = head(shreg_q);
            ser_en_d   = 1'b1;
            state_d    = SEND;
         end
         SEND: begin
            // ser_done is tested first so it beats a simultaneous timeout
            if (ser_done && byte_idx_q < LAST_IDX) begin
               byte_idx_d = byte_idx_q + 4'd1;
               shreg_d    = shreg_nx;
               timer_d    = '0;
               ser_data_d = head(shreg_nx);
            end else if (ser_done || timer_q == T_MAX) begin
               ser_en_d      = 1'b0;
               blk_done_d    = ser_done;
               err_timeout_d = !ser_done;
               timer_d       = '0;
               gap_d         = '0;
               state_d       = (GAP_CYC == 0) ? IDLE : GAP;
               busy_d        = (GAP_CYC != 0);
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         GAP: if (gap_q == G_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      endcase
      blk_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q       <= IDLE;
         shreg_q       <= '0;
         byte_idx_q    <= '0;
         timer_q       <= '0;
         gap_q         <= '0;
         ser_data_q    <= '0;
         blk_ready_q   <= 1'b0;
         ser_en_q      <= 1'b0;
         busy_q        <= 1'b0;
         blk_done_q    <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         byte_idx_q    <= byte_idx_d;
         timer_q       <= timer_d;
         gap_q         <= gap_d;
         ser_data_q    <= ser_data_d;
         blk_ready_q   <= blk_ready_d;
         ser_en_q      <= ser_en_d;
         busy_q        <= busy_d;
         blk_done_q    <= blk_done_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign blk_ready   = blk_ready_q;
   assign ser_data    = ser_data_q;
   assign ser_en      = ser_en_q;
   assign busy        = busy_q;
   assign byte_idx    = byte_idx_q;
   assign blk_done    = blk_done_q;
   assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_aes_byte_tx_ctrl.sv
// tb_aes_byte_tx_ctrl: MSB-first and LSB-first controllers driving a behavioural serializer;
// expected bytes are queued at issue and checked as the serializer consumes them.
module tb_aes_byte_tx_ctrl;
   localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] BLK_B = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
   localparam logic [127:0] BLK_C = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

   logic         clk = 1'b0;
   logic         rst;
   logic         bv[2], br[2], se[2], sdn[2], bsy[2], bdn[2], et[2], inj[2], md[2];
   logic [127:0] bd[2];
   logic [7:0]   sd[2], cur_exp[2], rec[2];
   logic [3:0]   bi[2];
   logic [7:0]   exp_q[$];
   int           cnt[2]      = '{0, 0};
   int           done_cnt[2] = '{0, 0};
   int           to_cnt[2]   = '{0, 0};
   int           stall_at    = -1;
   int           errors      = 0;
   int           checks      = 0;
   int           n;

   always #5 clk = ~clk;

   aes_byte_tx_ctrl #(.MSB_FIRST(1)) dut_msb (
      .clk(clk), .RST(rst), .blk_valid(bv[0]), .blk_data(bd[0]), .blk_ready(br[0]),
      .ser_data(sd[0]), .ser_en(se[0]), .ser_done(sdn[0]), .busy(bsy[0]),
      .byte_idx(bi[0]), .blk_done(bdn[0]), .err_timeout(et[0]));

   aes_byte_tx_ctrl #(.MSB_FIRST(0)) dut_lsb (
      .clk(clk), .RST(rst), .blk_valid(bv[1]), .blk_data(bd[1]), .blk_ready(br[1]),
      .ser_data(sd[1]), .ser_en(se[1]), .ser_done(sdn[1]), .busy(bsy[1]),
      .byte_idx(bi[1]), .blk_done(bdn[1]), .err_timeout(et[1]));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Serializer model: latches a byte on its first enabled cycle, shifts ser_data MSB-first
   // for 8 cycles and pulses ser_done on the 8th; stall_at freezes it on that byte index.
   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         md[l] = 1'b0;
         if (se[l] && !rst) begin
            if (cnt[l] == 0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ser_data_unexpected lane%0d: got %02h, required no byte", l, sd[l]);
               end else begin
                  cur_exp[l] = exp_q.pop_front();
                  chk("ser_data", sd[l], cur_exp[l]);
               end
            end
            if (stall_at >= 0 && int'(bi[l]) == stall_at) begin
               cnt[l] = 1;
            end else begin
               rec[l] = {rec[l][6:0], sd[l][3'(7 - cnt[l])]};
               cnt[l]++;
               if (cnt[l] == 8) begin
                  cnt[l] = 0;
                  md[l]  = 1'b1;
                  chk("serial_byte", rec[l], cur_exp[l]);
               end
            end
         end else begin
            cnt[l] = 0;
         end
         sdn[l] = md[l] | inj[l];
         if (bdn[l]) done_cnt[l]++;
         if (et[l]) to_cnt[l]++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [127:0] d, input int nb, input bit msb);
      for (int i = 0; i < nb; i++) exp_q.push_back(msb ? d[127 - 8*i -: 8] : d[8*i +: 8]);
   endtask

   // Called just after the handshake edge: LOAD cycle, then enable on the next edge.
   task automatic after_hs(input int l);
      chk("ready_low_load", br[l], 1'b0);
      chk("busy_set", bsy[l], 1'b1);
      chk("en_low_load", se[l], 1'b0);
      chk("idx_clear", bi[l], 4'd0);
      tick();
      chk("en_rise_2nd_edge", se[l], 1'b1);
   endtask

   task automatic send_blk(input int l, input logic [127:0] d, input bit hold);
      int w = 0;
      bv[l] = 1'b1;
      bd[l] = d;
      while (!br[l] && w < 500) begin
         tick();
         w++;
      end
      chk("ready_wait", br[l], 1'b1);
      tick();
      if (!hold) bv[l] = 1'b0;
      after_hs(l);
   endtask

   task automatic wait_done(input int l, input bit poke);
      int w = 0;
      while (!bdn[l] && w < 2000) begin
         tick();
         w++;
      end
      chk("blk_done_pulse", bdn[l], 1'b1);
      chk("en_low_at_done", se[l], 1'b0);
      chk("idx_last", bi[l], 4'd15);
      inj[l] = poke;
      tick();
      inj[l] = 1'b0;
      chk("blk_done_one_cycle", bdn[l], 1'b0);
      chk("ready_low_gap", br[l], 1'b0);
      chk("busy_gap", bsy[l], 1'b1);
      tick();
      chk("ready_after_gap", br[l], 1'b1);
      chk("busy_clear", bsy[l], 1'b0);
      chk("idx_hold_gap", bi[l], 4'd15);
      chk("en_low_idle", se[l], 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bv  = '{1'b0, 1'b0};
      bd  = '{128'h0, 128'h0};
      inj = '{1'b0, 1'b0};
      repeat (2) tick();
      chk("rst_ready", br[0], 1'b0);
      chk("rst_en", se[0], 1'b0);
      chk("rst_data", sd[0], 8'h00);
      chk("rst_busy", bsy[0], 1'b0);
      chk("rst_idx", bi[0], 4'd0);
      chk("rst_done", bdn[0], 1'b0);
      chk("rst_err", et[0], 1'b0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst0", br[0], 1'b1);
      chk("ready_after_rst1", br[1], 1'b1);

      push_exp(BLK_A, 16, 1'b1);
      send_blk(0, BLK_A, 1'b0);
      wait_done(0, 1'b0);
      chk("done_cnt_msb", done_cnt[0], 1);
      chk("queue_drained_msb", exp_q.size(), 0);

      push_exp(BLK_A, 16, 1'b0);
      send_blk(1, BLK_A, 1'b0);
      wait_done(1, 1'b1);
      chk("done_cnt_lsb", done_cnt[1], 1);
      chk("queue_drained_lsb", exp_q.size(), 0);

      // Valid held across two blocks; data changes right after the first capture.
      push_exp(BLK_B, 16, 1'b1);
      push_exp(BLK_C, 16, 1'b1);
      send_blk(0, BLK_B, 1'b1);
      bd[0] = BLK_C;
      wait_done(0, 1'b0);
      tick();
      bv[0] = 1'b0;
      after_hs(0);
      wait_done(0, 1'b1);
      chk("done_cnt_b2b", done_cnt[0], 3);
      chk("queue_drained_b2b", exp_q.size(), 0);

      push_exp(BLK_C, 6, 1'b1);
      stall_at = 5;
      send_blk(0, BLK_C, 1'b0);
      n = 0;
      while (bi[0] != 4'd5 && n < 500) begin
         tick();
         n++;
      end
      chk("reach_byte5", bi[0], 4'd5);
      n = 0;
      while (!et[0] && n < 200) begin
         tick();
         n++;
      end
      chk("timeout_edges", n, 65);
      chk("timeout_en_low", se[0], 1'b0);
      chk("timeout_no_done", bdn[0], 1'b0);
      tick();
      chk("err_one_cycle", et[0], 1'b0);
      chk("ready_low_gap_to", br[0], 1'b0);
      tick();
      chk("ready_after_to", br[0], 1'b1);
      stall_at = -1;
      chk("to_cnt", to_cnt[0], 1);
      chk("done_cnt_to", done_cnt[0], 3);
      chk("queue_drained_to", exp_q.size(), 0);

      push_exp(BLK_A, 16, 1'b1);
      send_blk(0, BLK_A, 1'b0);
      wait_done(0, 1'b0);
      chk("done_cnt_recover", done_cnt[0], 4);

      push_exp(BLK_B, 16, 1'b1);
      send_blk(0, BLK_B, 1'b0);
      n = 0;
      while (bi[0] != 4'd7 && n < 500) begin
         tick();
         n++;
      end
      chk("reach_byte7", bi[0], 4'd7);
      rst = 1'b1;
      tick();
      chk("midrst_en", se[0], 1'b0);
      chk("midrst_idx", bi[0], 4'd0);
      chk("midrst_busy", bsy[0], 1'b0);
      chk("midrst_done", bdn[0], 1'b0);
      chk("midrst_ready", br[0], 1'b0);
      chk("midrst_data", sd[0], 8'h00);
      rst = 1'b0;
      exp_q.delete();
      tick();
      chk("ready_after_midrst", br[0], 1'b1);

      inj[0] = 1'b1;
      tick();
      inj[0] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("idle_done_ready", br[0], 1'b1);
         chk("idle_done_busy", bsy[0], 1'b0);
         chk("idle_done_en", se[0], 1'b0);
         chk("idle_done_idx", bi[0], 4'd0);
         chk("idle_done_data", sd[0], 8'h00);
         chk("idle_done_pulse", bdn[0], 1'b0);
         tick();
      end
      chk("done_cnt_final", done_cnt[0], 4);
      chk("to_cnt_final", to_cnt[0], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
